// File: rtl/weighted_rr_read_scheduler_pkg.sv
// Shared constants, FSM encoding and helpers for the weighted round-robin
// read scheduler.
package weighted_rr_read_scheduler_pkg;

    localparam int NPORT = 4;
    localparam int DW    = 8;
    localparam int WW    = 4;

    // IDLE: no read issued last cycle. BURST: port cur is being drained.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Index of the set bit in a one-hot (or zero) 4-bit vector; zero maps to 0.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NPORT; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/weighted_rr_read_scheduler_rr_next_sel.sv
// Rotating-priority search: first eligible port among cur+1, cur+2, cur+3, cur.
module rr_next_sel
    import weighted_rr_read_scheduler_pkg::*;
(
    input  logic [1:0] cur,
    input  logic [3:0] elig,
    output logic       found,
    output logic [1:0] next
);

    // Walk the ring starting just after cur; cur itself is the last resort.
    always_comb begin
        logic [1:0] cand;
        found = 1'b0;
        next  = cur;
        cand  = cur;
        for (int i = 1; i <= NPORT; i++) begin
            cand = cur + 2'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                next  = cand;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_read_scheduler.sv
// Weighted round-robin drain of four FIFOs onto one bus. A port keeps the
// grant for up to weight[port] consecutive reads, then the grant rotates.
// Read data returns one cycle after ren; valid/grant_id/dout follow it.
//
// Handshake: ren[i] is a single-cycle read strobe, only ever raised when
// empty[i]=0 and weight[i]!=0; the FIFO word arrives the following cycle,
// where valid=1 marks dout as a real word from port grant_id. There is no
// backpressure: the downstream consumer must accept every valid word.
module weighted_rr_read_scheduler
    import weighted_rr_read_scheduler_pkg::*;
#(
    parameter int DW = weighted_rr_read_scheduler_pkg::DW,
    parameter int WW = weighted_rr_read_scheduler_pkg::WW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    empty,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    input  logic          cfg_wen,
    input  logic [1:0]    cfg_idx,
    input  logic [WW-1:0] cfg_weight,
    output logic [3:0]    ren,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [1:0]    grant_id
);

    logic [WW-1:0] weight [NPORT];
    logic [WW-1:0] used;
    logic [1:0]    cur;
    logic [0:0]    state;

    logic [3:0]    elig;
    logic          stay;
    logic          found;
    logic [1:0]    next;
    logic [1:0]    ren_idx;

    // A port may be picked only when it has data and a nonzero quota.
    always_comb begin
        elig = 4'b0000;
        for (int i = 0; i < NPORT; i++) begin
            elig[i] = !empty[i] && (weight[i] != '0);
        end
    end

    // Continue the current burst while data remains and quota is left.
    always_comb begin
        stay = (state == ST_BURST) && !empty[cur] && (used < weight[cur]);
    end

    rr_next_sel u_next_sel (
        .cur   (cur),
        .elig  (elig),
        .found (found),
        .next  (next)
    );

    // Read enable: stay on cur, else move on the same cycle; silent in reset.
    always_comb begin
        ren = 4'b0000;
        if (rst_n) begin
            if (stay) begin
                ren[cur] = 1'b1;
            end else if (found) begin
                ren[next] = 1'b1;
            end
        end
    end

    always_comb begin
        ren_idx = onehot_to_idx(ren);
    end

    // Weight table: reset to quota 1 everywhere, reset wins over writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORT; i++) begin
                weight[i] <= WW'(1);
            end
        end else if (cfg_wen) begin
            weight[cfg_idx] <= cfg_weight;
        end
    end

    // Burst FSM: track the granted port and how many reads it has used.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cur   <= 2'd0;
            used  <= '0;
        end else if (stay) begin
            used  <= used + WW'(1);
        end else if (found) begin
            state <= ST_BURST;
            cur   <= next;
            used  <= WW'(1);
        end else begin
            state <= ST_IDLE;
        end
    end

    // Output tag: the word read this cycle is presented next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            grant_id <= 2'd0;
        end else begin
            valid    <= |ren;
            grant_id <= ren_idx;
        end
    end

    // Data mux by the registered grant; zero when nothing was read.
    always_comb begin
        dout = '0;
        if (valid) begin
            case (grant_id)
                2'd0:    dout = a;
                2'd1:    dout = b;
                2'd2:    dout = c;
                default: dout = d;
            endcase
        end
    end

endmodule

// File: tb/tb_weighted_rr_read_scheduler.sv
// Directed bench for weighted_rr_read_scheduler: the driver checks ren each
// cycle and queues the expected {grant_id, dout}; a monitor pops on valid.
module tb_weighted_rr_read_scheduler;
    import weighted_rr_read_scheduler_pkg::*;

    logic          clk;
    logic          rst_n;
    logic [3:0]    empty;
    logic [DW-1:0] a, b, c, d;
    logic          cfg_wen;
    logic [1:0]    cfg_idx;
    logic [WW-1:0] cfg_weight;
    logic [3:0]    ren;
    logic [DW-1:0] dout;
    logic          valid;
    logic [1:0]    grant_id;

    logic [DW-1:0] port_data [NPORT];
    logic [DW+1:0] exp_q [$];
    int            vectors;
    int            miscompares;
    logic          mon_en;

    assign a = port_data[0];
    assign b = port_data[1];
    assign c = port_data[2];
    assign d = port_data[3];

    weighted_rr_read_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .empty      (empty),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .cfg_wen    (cfg_wen),
        .cfg_idx    (cfg_idx),
        .cfg_weight (cfg_weight),
        .ren        (ren),
        .dout       (dout),
        .valid      (valid),
        .grant_id   (grant_id)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        if (oh == 4'b0010) r = 2'd1;
        if (oh == 4'b0100) r = 2'd2;
        if (oh == 4'b1000) r = 2'd3;
        return r;
    endfunction

    // driver: apply one cycle of inputs, check ren, queue the expected word
    task automatic step(input logic rst_v, input logic [3:0] e, input logic [3:0] exp_ren,
                        input logic w_en, input logic [1:0] w_idx, input logic [WW-1:0] w_val,
                        input string tag);
        @(posedge clk);
        #1;
        rst_n      = rst_v;
        empty      = e;
        cfg_wen    = w_en;
        cfg_idx    = w_idx;
        cfg_weight = w_val;
        #1;
        vectors++;
        if (ren !== exp_ren) begin
            miscompares++;
            $display("FAIL %s ren: got %b expected %b", tag, ren, exp_ren);
        end
        if (exp_ren != 4'b0000) begin
            exp_q.push_back({idx_of(exp_ren), port_data[idx_of(exp_ren)]});
        end
    endtask

    task automatic run(input logic [3:0] e, input logic [3:0] exp_ren, input string tag);
        step(1'b1, e, exp_ren, 1'b0, 2'd0, '0, tag);
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [WW-1:0] w, input string tag);
        step(1'b1, 4'b1111, 4'b0000, 1'b1, idx, w, tag);
    endtask

    task automatic check_out_reset(input string tag);
        vectors++;
        if (valid !== 1'b0 || grant_id !== 2'd0 || dout !== '0) begin
            miscompares++;
            $display("FAIL %s outputs: got valid=%b grant_id=%0d dout=%0d expected 0/0/0",
                     tag, valid, grant_id, dout);
        end
    endtask

    // scoreboard monitor: pop and compare whenever dout is marked valid
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got grant_id=%0d dout=%0d expected no word",
                             grant_id, dout);
                end else begin
                    logic [DW+1:0] exp_w;
                    exp_w = exp_q.pop_front();
                    if ({grant_id, dout} !== exp_w) begin
                        miscompares++;
                        $display("FAIL word: got grant_id=%0d dout=%0d expected grant_id=%0d dout=%0d",
                                 grant_id, dout, exp_w[DW+1:DW], exp_w[DW-1:0]);
                    end
                end
            end else begin
                vectors++;
                if (dout !== '0 || valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_out: got valid=%b dout=%0d expected valid=0 dout=0",
                             valid, dout);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        empty       = 4'b1111;
        cfg_wen     = 1'b0;
        cfg_idx     = 2'd0;
        cfg_weight  = '0;
        port_data[0] = 8'd1;
        port_data[1] = 8'd2;
        port_data[2] = 8'd3;
        port_data[3] = 8'd4;

        // reset with data present: ren must stay low, outputs cleared
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, '0, "reset0");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, '0, "reset1");
        check_out_reset("reset_state");
        mon_en = 1'b1;

        // 1. plain rotation with quota 1 everywhere, starting at port 1
        run(4'b0000, 4'b0010, "rot0");
        run(4'b0000, 4'b0100, "rot1");
        run(4'b0000, 4'b1000, "rot2");
        run(4'b0000, 4'b0001, "rot3");
        run(4'b0000, 4'b0010, "rot4");

        // 2. weighted burst: port a gets three in a row
        cfg(2'd0, 4'd3, "cfg_w0_3");
        run(4'b0000, 4'b0100, "wb0");
        run(4'b0000, 4'b1000, "wb1");
        run(4'b0000, 4'b0001, "wb2");
        run(4'b0000, 4'b0001, "wb3");
        run(4'b0000, 4'b0001, "wb4");
        run(4'b0000, 4'b0010, "wb5");
        run(4'b0000, 4'b0100, "wb6");
        run(4'b0000, 4'b1000, "wb7");
        run(4'b0000, 4'b0001, "wb8");
        run(4'b0000, 4'b0001, "wb9");
        run(4'b0000, 4'b0001, "wb10");
        cfg(2'd0, 4'd1, "cfg_w0_1");

        // 3. lone port d: back-to-back reads, no bubble
        port_data[3] = 8'd85;
        run(4'b0111, 4'b1000, "lone0");
        run(4'b0111, 4'b1000, "lone1");
        run(4'b0111, 4'b1000, "lone2");
        run(4'b0111, 4'b1000, "lone3");

        // 4a. disabled port c is skipped
        cfg(2'd2, 4'd0, "cfg_w2_0");
        run(4'b0000, 4'b0001, "dis0");
        run(4'b0000, 4'b0010, "dis1");
        run(4'b0000, 4'b1000, "dis2");
        run(4'b0000, 4'b0001, "dis3");
        run(4'b0000, 4'b0010, "dis4");
        run(4'b0000, 4'b1000, "dis5");

        // 4b. empty flag rises mid-burst on b: move to d in that cycle
        cfg(2'd1, 4'd4, "cfg_w1_4");
        run(4'b0000, 4'b0001, "mid0");
        run(4'b0000, 4'b0010, "mid1");
        run(4'b0000, 4'b0010, "mid2");
        run(4'b0010, 4'b1000, "mid3");
        cfg(2'd1, 4'd1, "cfg_w1_1");
        cfg(2'd2, 4'd1, "cfg_w2_1");

        // 5. idle then wake on port c
        run(4'b1111, 4'b0000, "idle0");
        run(4'b1111, 4'b0000, "idle1");
        port_data[2] = 8'd139;
        run(4'b1011, 4'b0100, "wake0");
        run(4'b1011, 4'b0100, "wake1");
        run(4'b1111, 4'b0000, "wake2");

        // 6. reset in the middle of an a burst
        cfg(2'd0, 4'd3, "cfg_w0_3b");
        run(4'b1110, 4'b0001, "rb0");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, '0, "rb_rst0");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, '0, "rb_rst1");
        check_out_reset("rb_reset_state");
        run(4'b0000, 4'b0010, "rb1");
        run(4'b0000, 4'b0100, "rb2");
        run(4'b0000, 4'b1000, "rb3");
        run(4'b0000, 4'b0001, "rb4");
        run(4'b0000, 4'b0010, "rb5");

        // drain and confirm every queued word was seen
        run(4'b1111, 4'b0000, "drain0");
        run(4'b1111, 4'b0000, "drain1");
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d words pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
